// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with fixed-latency MULT(U)/DIV(U), MTHI/MTLO and architectural HI/LO.
// Results are computed at the start edge and held pending until the busy count expires.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        RdHi,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSV   = 3'd7
  } op_e;
  localparam logic [3:0] MUL_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);
  logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic [3:0]  r_cnt;
  logic        r_pend_wr;
  logic        w_accept, w_is_mul, w_is_div, w_sext_mul, w_neg_a, w_neg_b;
  logic [63:0] w_prod;
  logic [31:0] w_mag_a, w_mag_b, w_div_b, w_uq, w_ur, w_quo, w_rem;
  assign Busy       = r_cnt != 4'd0;
  assign HI         = r_hi;
  assign LO         = r_lo;
  assign Out        = RdHi ? r_hi : r_lo;
  assign w_accept   = Start && !Busy;
  assign w_is_mul   = Op == OP_MULT || Op == OP_MULTU;
  assign w_is_div   = Op == OP_DIV || Op == OP_DIVU;
  // Sign-extending both operands to 64 bits lets one unsigned multiplier serve MULT and MULTU.
  assign w_sext_mul = Op == OP_MULT;
  assign w_prod     = {{32{w_sext_mul & A[31]}}, A} * {{32{w_sext_mul & B[31]}}, B};
  // Signed division runs on magnitudes; quotient negated on sign mismatch, remainder follows dividend.
  assign w_neg_a    = Op == OP_DIV && A[31];
  assign w_neg_b    = Op == OP_DIV && B[31];
  assign w_mag_a    = w_neg_a ? -A : A;
  assign w_mag_b    = w_neg_b ? -B : B;
  assign w_div_b    = w_mag_b == 32'd0 ? 32'd1 : w_mag_b;
  assign w_uq       = w_mag_a / w_div_b;
  assign w_ur       = w_mag_a % w_div_b;
  assign w_quo      = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
  assign w_rem      = w_neg_a ? -w_ur : w_ur;
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_cnt     <= 4'd0;
      r_pend_wr <= 1'b0;
    end else if (Busy) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1 && r_pend_wr) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (w_accept) begin
      if (w_is_mul) begin
        {r_pend_hi, r_pend_lo} <= w_prod;
        r_cnt     <= MUL_N;
        r_pend_wr <= 1'b1;
      end else if (w_is_div) begin
        r_pend_hi <= w_rem;
        r_pend_lo <= w_quo;
        r_cnt     <= DIV_N;
        r_pend_wr <= B != 32'd0;
      end else if (Op == OP_MTHI) begin
        r_hi <= A;
      end else if (Op == OP_MTLO) begin
        r_lo <= A;
      end
    end
  end
endmodule
